instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads, registers the returned instruction
// for the decoder, and handles redirects, including ones that hit an outstanding read.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend, pend_n;
  logic [31:0] ir_n, ir_pc_n;
  logic        ir_valid_n;
  logic [31:0] target;

  assign target   = {redirect_pc[31:2], 2'b00};
  assign mem_req  = (state != HOLD);
  assign mem_addr = {pc[31:2], 2'b00};

  // NOTE: every next-value signal is defaulted to its current value first, so
  // no path through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    unique case (state)
      FETCH: begin
        if (redirect && mem_ack) begin
          pc_n = target;
        end else if (redirect) begin
          // The read already on the bus must finish at its original address.
          pend_n  = target;
          state_n = DISCARD;
        end else if (mem_ack) begin
          ir_n       = mem_rdata;
          ir_pc_n    = pc;
          pc_n       = pc + 32'd4;
          ir_valid_n = 1'b1;
          state_n    = HOLD;
        end
      end
      DISCARD: begin
        if (redirect) pend_n = target;
        if (mem_ack) begin
          pc_n    = redirect ? target : pend;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          ir_valid_n = 1'b0;
          pc_n       = target;
          state_n    = FETCH;
        end else if (dec_ready) begin
          ir_valid_n = 1'b0;
          state_n    = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      pend     <= 32'h0;
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend     <= pend_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

endmodule
